// File: rtl/mioc_flop_seq.sv
// Phase sequencer for a bank of mioc open-drain flop cells: clear/setup/strobe/hold/settle, then sample and compare q.
// Optional macro MIOC_SEQ_COMPL_CHECK_EN adds a qbar == ~q complement check to the response error.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// CLEAR  | in4 high on all cells (only when req_clr was set)
// SETUP  | in3 driven with the data to store
// STROBE | in3 held, in2 (write) or in1 (preset) high
// HOLD   | in3 held after the strobe drops
// SETTLE | all cell inputs low while q settles
// CHECK  | sample q and compare against the expected value
// RESP   | response presented until rsp_ready
module mioc_flop_seq #(
    parameter int WIDTH      = 8,
    parameter int CLR_CYC    = 2,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 1,
    parameter int HOLD_CYC   = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic             req_clr,
    input  logic [WIDTH-1:0] req_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_q,
    output logic             rsp_err,
    output logic [7:0]       err_cnt,
    output logic [WIDTH-1:0] flop_in1,
    output logic [WIDTH-1:0] flop_in2,
    output logic [WIDTH-1:0] flop_in3,
    output logic [WIDTH-1:0] flop_in4,
    input  logic [WIDTH-1:0] flop_q,
    input  logic [WIDTH-1:0] flop_qbar
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_STROBE = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_SETTLE = 3'd5;
    localparam logic [2:0] S_CHECK  = 3'd6;
    localparam logic [2:0] S_RESP   = 3'd7;

    localparam logic [3:0] CLR_LD    = 4'(CLR_CYC - 1);
    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);

    logic [2:0]       state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic             op_r, op_nxt;
    logic [WIDTH-1:0] data_r, data_nxt;
    logic [WIDTH-1:0] drive_val;
    logic [WIDTH-1:0] in1_nxt, in2_nxt, in3_nxt, in4_nxt;
    logic [WIDTH-1:0] expected;
    logic             compl_err;
    logic             chk_err;

    assign req_ready = (state == S_IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op_r;
        data_nxt  = data_r;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    op_nxt   = req_op;
                    data_nxt = req_data;
                    if (req_clr) begin
                        state_nxt = S_CLEAR;
                        cnt_nxt   = CLR_LD;
                    end else begin
                        state_nxt = S_SETUP;
                        cnt_nxt   = SETUP_LD;
                    end
                end
            end
            S_CLEAR: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_SETUP;
                    cnt_nxt   = SETUP_LD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_SETUP: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_STROBE;
                    cnt_nxt   = STROBE_LD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_STROBE: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = HOLD_LD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_HOLD: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_SETTLE;
                    cnt_nxt   = SETTLE_LD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_SETTLE: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_CHECK;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_CHECK: state_nxt = S_RESP;
            S_RESP: begin
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Cell inputs are decoded from the next state so they are registered and line up with the state itself.
    always_comb begin
        drive_val = op_nxt ? {WIDTH{1'b1}} : data_nxt;
        in1_nxt   = '0;
        in2_nxt   = '0;
        in3_nxt   = '0;
        in4_nxt   = '0;
        case (state_nxt)
            S_CLEAR:  in4_nxt = '1;
            S_SETUP:  in3_nxt = drive_val;
            S_STROBE: begin
                in3_nxt = drive_val;
                if (op_nxt) in1_nxt = '1;
                else        in2_nxt = '1;
            end
            S_HOLD:   in3_nxt = drive_val;
            default:  ;
        endcase
    end

    assign expected = op_r ? {WIDTH{1'b1}} : data_r;

`ifdef MIOC_SEQ_COMPL_CHECK_EN
    assign compl_err = |(flop_qbar ^ ~flop_q);
`else
    logic qbar_unused;
    assign qbar_unused = ^flop_qbar;
    assign compl_err   = 1'b0;
`endif

    assign chk_err = (flop_q != expected) | compl_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            op_r      <= 1'b0;
            data_r    <= '0;
            flop_in1  <= '0;
            flop_in2  <= '0;
            flop_in3  <= '0;
            flop_in4  <= '0;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
            rsp_err   <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            op_r      <= op_nxt;
            data_r    <= data_nxt;
            flop_in1  <= in1_nxt;
            flop_in2  <= in2_nxt;
            flop_in3  <= in3_nxt;
            flop_in4  <= in4_nxt;
            rsp_valid <= (state_nxt == S_RESP);
            if (state == S_CHECK) begin
                rsp_q   <= flop_q;
                rsp_err <= chk_err;
                if (chk_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule
